// File: rtl/window_fetch_ctrl_if.sv
// Handshake bundle between window_fetch_ctrl, pixel memory, windowBuffer and the Sobel core.
// master = fetch controller side, slave = memory/windowBuffer/core side.
interface window_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              start_read;
    logic              read_done;
    logic [7:0]        data_r;
    logic [3:0]        count;
    logic              start_shift;
    logic [1:0]        shift_direc;
    logic              shift_done;
    logic              win_valid;
    logic              win_ack;
    logic [ADDR_W-1:0] cx;
    logic [ADDR_W-1:0] cy;

    modport master (
        output mem_rd_en, mem_addr, start_read, data_r, count, start_shift, shift_direc,
               win_valid, cx, cy,
        input  mem_rdata, read_done, shift_done, win_ack
    );

    modport slave (
        input  mem_rd_en, mem_addr, start_read, data_r, count, start_shift, shift_direc,
               win_valid, cx, cy,
        output mem_rdata, read_done, shift_done, win_ack
    );
endinterface

// File: rtl/window_fetch_ctrl.sv
// Snake-order 3x3 window walker: fetches pixels into windowBuffer slots, issues shifts and
// presents each resident window to the Sobel core with a valid/ack handshake.
module window_fetch_ctrl #(
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 16,
    parameter int unsigned ADDR_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    window_fetch_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StLoadAddr, StLoadData, StLoadWait, StPresent, StShift, StFinish
    } state_e;

    // Which slots still need loading after the last move.
    typedef enum logic [1:0] {ListFull, ListRight, ListLeft, ListDown} list_e;

    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CxLast  = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] CyLast  = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] RowLen  = ADDR_W'(IMG_W);

    state_e            state_q, state_d;
    list_e             list_q, list_d;
    logic [3:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] cx_q, cx_d;
    logic [ADDR_W-1:0] cy_q, cy_d;
    logic              pass_left_q, pass_left_d;
    logic [1:0]        dir_q, dir_d;
    logic [7:0]        data_q, data_d;
    logic [3:0]        count_q, count_d;

    logic [3:0]        slot;
    logic [3:0]        last_idx;
    logic [3:0]        col;
    logic [3:0]        row;
    logic [ADDR_W-1:0] pix_x;
    logic [ADDR_W-1:0] pix_y;
    logic [ADDR_W-1:0] rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            list_q      <= ListFull;
            idx_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            pass_left_q <= 1'b0;
            dir_q       <= '0;
            data_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            list_q      <= list_d;
            idx_q       <= idx_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            pass_left_q <= pass_left_d;
            dir_q       <= dir_d;
            data_q      <= data_d;
            count_q     <= count_d;
        end
    end

    // Map list position to windowBuffer slot and slot to pixel address.
    always_comb begin
        slot     = idx_q;
        last_idx = 4'd2;
        unique case (list_q)
            ListFull: begin
                slot     = idx_q;
                last_idx = 4'd8;
            end
            ListRight: slot = 4'd2 + 4'd3 * idx_q;
            ListLeft:  slot = 4'd3 * idx_q;
            ListDown:  slot = 4'd6 + idx_q;
            default:   slot = idx_q;
        endcase
        col     = slot % 4'd3;
        row     = slot / 4'd3;
        pix_x   = cx_q - AddrOne + ADDR_W'(col);
        pix_y   = cy_q - AddrOne + ADDR_W'(row);
        rd_addr = pix_y * RowLen + pix_x;
    end

    always_comb begin
        state_d     = state_q;
        list_d      = list_q;
        idx_d       = idx_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        pass_left_d = pass_left_q;
        dir_d       = dir_q;
        data_d      = data_q;
        count_d     = count_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StLoadAddr;
                    cx_d        = AddrOne;
                    cy_d        = AddrOne;
                    list_d      = ListFull;
                    idx_d       = '0;
                    pass_left_d = 1'b0;
                end
            end
            StLoadAddr: state_d = StLoadData;
            StLoadData: begin
                data_d  = bus.mem_rdata;
                count_d = slot;
                state_d = StLoadWait;
            end
            StLoadWait: begin
                if (bus.read_done) begin
                    if (idx_q == last_idx) begin
                        state_d = StPresent;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StLoadAddr;
                    end
                end
            end
            StPresent: begin
                if (bus.win_ack) begin
                    idx_d   = '0;
                    state_d = StShift;
                    if (!pass_left_q && (cx_q < CxLast)) begin
                        dir_d  = 2'b01;
                        cx_d   = cx_q + AddrOne;
                        list_d = ListRight;
                    end else if (pass_left_q && (cx_q > AddrOne)) begin
                        dir_d  = 2'b11;
                        cx_d   = cx_q - AddrOne;
                        list_d = ListLeft;
                    end else if (cy_q < CyLast) begin
                        dir_d       = 2'b10;
                        cy_d        = cy_q + AddrOne;
                        list_d      = ListDown;
                        pass_left_d = ~pass_left_q;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StShift: begin
                if (bus.shift_done) state_d = StLoadAddr;
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o          = (state_q != StIdle) && (state_q != StFinish);
        done_o          = (state_q == StFinish);
        bus.mem_rd_en   = (state_q == StLoadAddr);
        bus.mem_addr    = (state_q == StLoadAddr) ? rd_addr : '0;
        bus.start_read  = (state_q == StLoadWait);
        bus.data_r      = data_q;
        bus.count       = count_q;
        bus.start_shift = (state_q == StShift);
        bus.shift_direc = (state_q == StShift) ? dir_q : 2'b00;
        bus.win_valid   = (state_q == StPresent);
        bus.cx          = cx_q;
        bus.cy          = cy_q;
    end

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Directed bench: 5x4 frame (plain, stalled, reset mid-frame, restart) and a 3x3 frame.
module tb_window_fetch_ctrl;

    localparam int unsigned AW = 16;

    logic clk = 1'b0;
    logic rst;
    logic start_a, busy_a, done_a;
    logic start_b, busy_b, done_b;

    always #5 clk = ~clk;

    window_fetch_ctrl_if #(.ADDR_W(AW)) bus_a ();
    window_fetch_ctrl_if #(.ADDR_W(AW)) bus_b ();

    window_fetch_ctrl #(.IMG_W(5), .IMG_H(4), .ADDR_W(AW)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a), .bus(bus_a)
    );

    window_fetch_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(AW)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b), .bus(bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory models: pixel(x,y) = y*W + x, which equals its address.
    always @(posedge clk) begin
        bus_a.mem_rdata <= bus_a.mem_rd_en ? bus_a.mem_addr[7:0] : 8'hEE;
        bus_b.mem_rdata <= bus_b.mem_rd_en ? bus_b.mem_addr[7:0] : 8'hEE;
    end

    int   rd_hold_a  = 0;
    int   ack_hold_a = 0;
    logic spur_a     = 1'b0;

    assign bus_a.read_done  = bus_a.start_read && (rd_hold_a == 0);
    assign bus_a.shift_done = bus_a.start_shift;
    assign bus_a.win_ack    = (bus_a.win_valid && (ack_hold_a == 0)) || spur_a;
    assign bus_b.read_done  = bus_b.start_read;
    assign bus_b.shift_done = bus_b.start_shift;
    assign bus_b.win_ack    = bus_b.win_valid;

    always @(posedge clk) begin
        if (bus_a.start_read && rd_hold_a > 0) rd_hold_a <= rd_hold_a - 1;
        if (bus_a.win_valid && ack_hold_a > 0) ack_hold_a <= ack_hold_a - 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame logs for DUT A.
    int          reads_a, done_n_a, stab_err_a, bad_a;
    int          rd_stall_a, rd_stall_max_a, ack_wait_a, ack_wait_max_a;
    logic [31:0] win_q[$];
    logic [1:0]  sh_q[$];
    logic [11:0] ld_q[$];
    logic        prev_sr, prev_wv;
    logic [7:0]  prev_data;
    logic [3:0]  prev_count;
    logic [15:0] prev_cx, prev_cy;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.mem_rd_en) reads_a <= reads_a + 1;
            if (bus_a.start_read && bus_a.read_done) ld_q.push_back({bus_a.count, bus_a.data_r});
            if (bus_a.start_shift && bus_a.shift_done) sh_q.push_back(bus_a.shift_direc);
            if (bus_a.win_valid && bus_a.win_ack) win_q.push_back({bus_a.cx, bus_a.cy});
            if (done_a) done_n_a <= done_n_a + 1;
            if ((bus_a.start_read && (bus_a.start_shift || bus_a.mem_rd_en || bus_a.win_valid)) ||
                (bus_a.win_valid && (bus_a.start_shift || bus_a.mem_rd_en)))
                bad_a <= bad_a + 1;
            if ((prev_sr && bus_a.start_read &&
                 (bus_a.data_r != prev_data || bus_a.count != prev_count)) ||
                (prev_wv && bus_a.win_valid && (bus_a.cx != prev_cx || bus_a.cy != prev_cy)))
                stab_err_a <= stab_err_a + 1;
            if (bus_a.start_read && !bus_a.read_done) begin
                rd_stall_a <= rd_stall_a + 1;
                if (rd_stall_a + 1 > rd_stall_max_a) rd_stall_max_a <= rd_stall_a + 1;
            end else begin
                rd_stall_a <= 0;
            end
            if (bus_a.win_valid && !bus_a.win_ack) begin
                ack_wait_a <= ack_wait_a + 1;
                if (ack_wait_a + 1 > ack_wait_max_a) ack_wait_max_a <= ack_wait_a + 1;
            end else begin
                ack_wait_a <= 0;
            end
        end
        prev_sr    <= bus_a.start_read;
        prev_wv    <= bus_a.win_valid;
        prev_data  <= bus_a.data_r;
        prev_count <= bus_a.count;
        prev_cx    <= bus_a.cx;
        prev_cy    <= bus_a.cy;
    end

    // Logs for DUT B.
    int          reads_b = 0, shifts_b = 0, wins_b = 0, done_n_b = 0, ack_at_b = 0, done_at_b = 0;
    logic [31:0] win0_b = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_b.mem_rd_en) reads_b <= reads_b + 1;
            if (bus_b.start_shift) shifts_b <= shifts_b + 1;
            if (bus_b.win_valid && bus_b.win_ack) begin
                wins_b   <= wins_b + 1;
                win0_b   <= {bus_b.cx, bus_b.cy};
                ack_at_b <= cyc;
            end
            if (done_b) begin
                done_n_b  <= done_n_b + 1;
                done_at_b <= cyc;
            end
        end
    end

    logic [31:0] exp_win[6] = '{{16'd1, 16'd1}, {16'd2, 16'd1}, {16'd3, 16'd1},
                                {16'd3, 16'd2}, {16'd2, 16'd2}, {16'd1, 16'd2}};
    logic [1:0]  exp_sh[5]  = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
    logic [11:0] exp_ld[12] = '{{4'd0, 8'd0}, {4'd1, 8'd1}, {4'd2, 8'd2}, {4'd3, 8'd5},
                                {4'd4, 8'd6}, {4'd5, 8'd7}, {4'd6, 8'd10}, {4'd7, 8'd11},
                                {4'd8, 8'd12}, {4'd2, 8'd3}, {4'd5, 8'd8}, {4'd8, 8'd13}};

    task automatic clear_a();
        reads_a = 0; done_n_a = 0; stab_err_a = 0; bad_a = 0;
        rd_stall_a = 0; rd_stall_max_a = 0; ack_wait_a = 0; ack_wait_max_a = 0;
        win_q.delete(); sh_q.delete(); ld_q.delete();
    endtask

    task automatic check_reset_outputs(input string pre);
        check_eq({pre, "_ctl"}, {24'd0, busy_a, done_a, bus_a.mem_rd_en, bus_a.start_read,
                                 bus_a.start_shift, bus_a.win_valid, bus_a.shift_direc}, 32'd0);
        check_eq({pre, "_data"}, {20'd0, bus_a.count, bus_a.data_r}, 32'd0);
        check_eq({pre, "_cxcy"}, {bus_a.cx, bus_a.cy}, 32'd0);
        check_eq({pre, "_addr"}, {16'd0, bus_a.mem_addr}, 32'd0);
    endtask

    // mode 0: plain, 1: stalls + spurious ack, 2: start pulses while busy.
    task automatic run_a(input int mode);
        bit fin = 1'b0;
        clear_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 3000 && !fin; k++) begin
            start_a = (mode == 2) && (k == 20 || k == 60);
            spur_a  = (mode == 1) && (k == 3 || k == 4);
            @(negedge clk);
            if (!busy_a) fin = 1'b1;
        end
        start_a = 1'b0;
        spur_a  = 1'b0;
        check_eq("frame_end", {31'd0, fin}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame_a(input string pre);
        check_eq({pre, "_nwin"}, win_q.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("%s_win%0d", pre, i),
                     (i < win_q.size()) ? win_q[i] : 32'hDEAD, exp_win[i]);
        check_eq({pre, "_nshift"}, sh_q.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("%s_shift%0d", pre, i),
                     (i < sh_q.size()) ? {30'd0, sh_q[i]} : 32'hDEAD, {30'd0, exp_sh[i]});
        check_eq({pre, "_reads"}, reads_a, 32'd24);
        check_eq({pre, "_loads"}, ld_q.size(), 32'd24);
        check_eq({pre, "_done"}, done_n_a, 32'd1);
        check_eq({pre, "_overlap"}, bad_a, 32'd0);
    endtask

    initial begin
        bit hit;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Plain frame: order, shifts, load slot/data values.
        run_a(0);
        check_frame_a("A");
        for (int i = 0; i < 12; i++)
            check_eq($sformatf("A_load%0d", i),
                     (i < ld_q.size()) ? {20'd0, ld_q[i]} : 32'hDEAD, {20'd0, exp_ld[i]});

        // Stalled handshakes and a spurious ack during loads.
        rd_hold_a  = 5;
        ack_hold_a = 10;
        run_a(1);
        check_frame_a("B");
        check_eq("B_rd_stall", rd_stall_max_a, 32'd5);
        check_eq("B_ack_wait", ack_wait_max_a, 32'd10);
        check_eq("B_stable", stab_err_a, 32'd0);

        // Reset during the third window's loads.
        clear_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            @(negedge clk);
            if (win_q.size() >= 2 && reads_a >= 14) hit = 1'b1;
        end
        check_eq("C_reach_win3", {31'd0, hit}, 32'd1);
        check_eq("C_busy_before", {31'd0, busy_a}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("C_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("C_no_done", done_n_a, 32'd0);
        check_eq("C_idle", {31'd0, busy_a}, 32'd0);

        // Restart after abort, with ignored start pulses mid-frame.
        run_a(2);
        check_frame_a("D");

        // 3x3 frame on the second instance.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 500 && !hit; k++) begin
            @(negedge clk);
            if (!busy_b) hit = 1'b1;
        end
        repeat (3) @(negedge clk);
        check_eq("E_frame_end", {31'd0, hit}, 32'd1);
        check_eq("E_nwin", wins_b, 32'd1);
        check_eq("E_win0", win0_b, {16'd1, 16'd1});
        check_eq("E_reads", reads_b, 32'd9);
        check_eq("E_shifts", shifts_b, 32'd0);
        check_eq("E_done", done_n_b, 32'd1);
        check_eq("E_done_lat", done_at_b - ack_at_b, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
